ts_conv_arbiter: RTL and testbench
==================================

Name: ts_conv_arbiter

Overview:
- Shares one two's-complement-to-sign-magnitude conversion unit (T_to_S) between NUM_REQ requesters in the LDPC decoder datapath.
- Requesters are variable-node and check-node message paths. Each presents a DATA_WIDTH two's-complement LLR.
- The block grants requesters round-robin, converts the granted word, and returns the result through a registered valid/ready output tagged with the requester ID.

Parameters:
- DATA_WIDTH, 6, input LLR width (two's complement); the result is DATA_WIDTH+1 bits.
- NUM_REQ, 4, number of requesters (2..16).
- ID_WIDTH, 2, width of the requester ID; must equal clog2(NUM_REQ), and elaboration fails otherwise.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened inputs; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot grant/accept; at most one bit high per cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_WIDTH+1  sign-magnitude result: MSB is the sign, low DATA_WIDTH bits are the magnitude.
- out_id  out  ID_WIDTH  index of the requester that produced out_data.
- busy  out  1  high while out_valid is set or any req_valid is set.

Behaviour:
- Reset: one clock with rst high drives the following state on the next edge:
  - out_valid=0, out_data=0, out_id=0.
  - round-robin pointer rr_ptr=0.
  - req_ready is combinationally 0 while rst is high.
  - Any transaction in flight is discarded and is not replayed.
- Accept condition: acc = !out_valid || out_ready. Skid-free; one output register.
- Grant (combinational):
  - When acc=1, req_ready selects the first requester with req_valid set, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - When acc=0, req_ready=0.
  - A requester transfers on the cycle where its req_valid and req_ready are both 1.
- On a transfer from requester g at edge t:
  - out_data <= T_to_S(req_data[g]); out_id <= g; out_valid <= 1.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Latency is 1 cycle, req-to-out.
- With no transfer and out_ready=1, out_valid <= 0. rr_ptr is unchanged when there is no transfer.
- Simultaneous consume and accept (out_valid=1, out_ready=1, new transfer): the register is overwritten in the same edge. Sustained throughput is 1 result per cycle.
- Stall: while out_valid=1 and out_ready=0, out_data, out_id and out_valid hold and no req_ready is asserted. Requesters must hold req_valid and req_data stable; the block does not check this.
- Conversion is combinational inside the T_to_S instance: x>=0 gives {0, x zero-extended}; x<0 gives {1, -x}. The most negative input 100000 maps to 1_100000 (magnitude 32 is representable because of the extra bit).
- Fairness: a requester holding req_valid is granted within NUM_REQ accept cycles.
- State machine (explicit 2-state):
  - EMPTY→FULL on a transfer.
  - FULL→EMPTY on out_ready with no transfer.
  - FULL→FULL on stall, or on consume plus transfer.
  - out_valid = (state==FULL).
- busy is combinational.

Decomposition:
- Shared package ldpc_util_pkg:
  - LLR_WIDTH=6.
  - function clog2.
  - constant SM_WIDTH=LLR_WIDTH+1.
  - typedef for the sign-magnitude word.
  - the EMPTY/FULL state encoding.
- Sub-modules:
  - T_to_S, instantiated once with DATA_WIDTH.
  - rr_arbiter (NUM_REQ): takes the request vector, rr_ptr and enable; outputs a one-hot grant and the granted index.

Test Plan:
- Reset mid-stall: out_valid=1, out_ready=0, then rst=1 for 1 cycle → out_valid=0, out_data=0, out_id=0, rr_ptr=0, no req_ready during rst.
- Single requester, out_ready=1: req 2 presents 6'b111101 (-3) → next cycle out_valid=1, out_data=7'b1000011, out_id=2. Then 6'b000101 → 7'b0000101. Then 6'b100000 → 7'b1100000. Then 6'b000000 → 7'b0000000.
- All 4 req_valid held, out_ready=1 from reset → grant order 0,1,2,3,0,… one per cycle; out_id follows the same sequence with 1-cycle lag.
- Backpressure: out_ready=0 for 3 cycles while reqs are pending → req_ready=0 and out_data/out_id held stable. When out_ready=1, the next grant goes to (last granted+1) with no result lost or duplicated.
- Exhaustive conversion: sweep all 64 inputs through requester 3 → out_data matches the sign-magnitude golden model for every value and out_id=3 throughout.
- Fairness: req 0 held continuously, req 1 and req 3 toggling randomly, random out_ready → no requester waits more than 4 accept cycles; scoreboard count per ID equals transfers issued.

Source files
------------

// File: rtl/ldpc_util_pkg.sv
// Shared definitions for the LDPC decoder datapath utilities.
//   LLR_WIDTH  : default two's-complement LLR width
//   SM_WIDTH   : sign-magnitude word width (one extra bit so -2^(N-1) fits)
//   sm_word_t  : sign-magnitude word type
//   buf_state_t: occupancy encoding of a single-entry output register
//   clog2      : ceiling log2, usable in constant expressions
package ldpc_util_pkg;

  localparam int LLR_WIDTH = 6;
  localparam int SM_WIDTH  = LLR_WIDTH + 1;

  typedef logic [SM_WIDTH-1:0] sm_word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_t;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/T_to_S.sv
// Two's-complement to sign-magnitude converter (purely combinational).
//   twos : DATA_WIDTH-bit two's-complement input
//   sm   : DATA_WIDTH+1-bit result, MSB = sign, low DATA_WIDTH bits = magnitude
module T_to_S #(
  parameter int DATA_WIDTH = 6
) (
  input  logic [DATA_WIDTH-1:0] twos,
  output logic [DATA_WIDTH:0]   sm
);

  logic             sign;
  logic [DATA_WIDTH:0] ext;
  logic [DATA_WIDTH:0] mag;

  // Negation is done one bit wider than the input so the most negative
  // value produces a magnitude of 2^(DATA_WIDTH-1) instead of overflowing.
  assign sign = twos[DATA_WIDTH-1];
  assign ext  = {sign, twos};
  assign mag  = sign ? (~ext + 1'b1) : ext;
  assign sm   = {sign, mag[DATA_WIDTH-1:0]};

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req       : request vector
//   ptr       : highest-priority index for this cycle (must be < NUM_REQ)
//   en        : when low, no grant is issued
//   grant     : one-hot grant (all zero if en is low or no request)
//   grant_idx : index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  input  logic                 en,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx
);

  always_comb begin
    int   pos;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    if (en) begin
      // Walk ptr, ptr+1, ... wrapping at NUM_REQ; first hit wins.
      for (int i = 0; i < NUM_REQ; i++) begin
        pos = int'(ptr) + i;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        if (!found && req[pos]) begin
          found      = 1'b1;
          grant[pos] = 1'b1;
          grant_idx  = IDX_WIDTH'(pos);
        end
      end
    end
  end

endmodule

// File: rtl/ts_conv_arbiter.sv
// Round-robin shared two's-complement to sign-magnitude converter.
// NUM_REQ requesters compete for one T_to_S unit; the granted word is
// converted and captured in a single output register tagged with the
// requester index. Latency is one cycle, throughput one result per cycle.
//   clk, rst  : clock, synchronous active-high reset
//   req_valid : per-requester valid
//   req_data  : flattened inputs, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_ready : one-hot grant/accept
//   out_valid, out_ready, out_data, out_id : result handshake
//   busy      : output occupied or any request pending
module ts_conv_arbiter
  import ldpc_util_pkg::*;
#(
  parameter int DATA_WIDTH = LLR_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH:0]           out_data,
  output logic [ID_WIDTH-1:0]           out_id,
  output logic                          busy
);

  generate
    if (ID_WIDTH != clog2(NUM_REQ)) begin : g_bad_id_width
      $error("ts_conv_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("ts_conv_arbiter: NUM_REQ must be within 2..16");
    end
  endgenerate

  buf_state_t            state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic                  acc;
  logic                  arb_en;
  logic                  transfer;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   next_ptr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [DATA_WIDTH:0]   conv_data;

  assign out_valid = (state == ST_FULL);
  // Single output register, no skid: accept only when it is empty or
  // being drained this cycle.
  assign acc       = (state == ST_EMPTY) || out_ready;
  assign arb_en    = acc && !rst;
  assign busy      = out_valid || (|req_valid);

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (ID_WIDTH)
  ) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .en        (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;
  assign transfer  = |grant;
  assign sel_data  = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr  = (grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  T_to_S #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_conv (
    .twos (sel_data),
    .sm   (conv_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      out_data <= '0;
      out_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (transfer) state <= ST_FULL;
        ST_FULL:  if (!transfer && out_ready) state <= ST_EMPTY;
        default:  state <= ST_EMPTY;
      endcase
      if (transfer) begin
        out_data <= conv_data;
        out_id   <= grant_idx;
        rr_ptr   <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_ts_conv_arbiter.sv
// Directed testbench for ts_conv_arbiter (NUM_REQ=4, DATA_WIDTH=6).
module tb_ts_conv_arbiter;
  import ldpc_util_pkg::*;

  localparam int DW = 6;
  localparam int NR = 4;
  localparam int IW = 2;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [DW:0]      out_data;
  logic [IW-1:0]    out_id;
  logic             busy;

  int total;
  int bad;

  ts_conv_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .ID_WIDTH   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [DW-1:0] v);
    req_data[k*DW +: DW] = v;
  endtask

  // Independent golden model: magnitude is |v| as an integer.
  function automatic sm_word_t golden(input int v);
    int mag;
    logic s;
    s   = (v >= 32);
    mag = s ? (64 - v) : v;
    return {s, 6'(mag)};
  endfunction

  task automatic chk_out(input string tag, input logic [IW-1:0] id, input sm_word_t d);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_id"}, 32'(out_id), 32'(id));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    $display("xfer %s id=%0d data=%b", tag, out_id, out_data);
  endtask

  // Fairness model state
  logic [NR-1:0] pend;
  int            wait_cnt [NR];
  int            issued   [NR];
  int            consumed [NR];
  logic          m_valid;
  logic [IW-1:0] m_id;
  int            m_ptr;

  initial begin
    logic [DW-1:0] vals [4];
    sm_word_t      exps [4];
    logic [NR-1:0] exp_gnt;
    int            g;
    logic          acc;

    total = 0;
    bad   = 0;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Fill the register from requester 1, then stall
    req_valid = 4'b0010; set_data(1, 6'd7);
    #1;
    chk("first_grant", 32'(req_ready), 32'b0010);
    chk("busy_req", 32'(busy), 32'd1);
    tick();
    req_valid = 4'b1111;
    #1;
    chk_out("stall_load", 2'd1, 7'b0000111);
    chk("stall_noready", 32'(req_ready), 32'd0);
    tick();
    chk_out("stall_hold", 2'd1, 7'b0000111);

    // Reset while stalled
    rst = 1'b1;
    #1;
    chk("rst_noready", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; req_valid = '0;
    #1;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_data", 32'(out_data), 32'd0);
    chk("rst2_id", 32'(out_id), 32'd0);

    // All requesters active: rotation 0,1,2,3,0 starting from ptr=0
    req_data = {6'd4, 6'd3, 6'd2, 6'd1};
    req_valid = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      tick();
      chk_out("rr_out", 2'(i % 4), 7'((i % 4) + 1));
    end

    // Backpressure: result id 0 held for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_noready", 32'(req_ready), 32'd0);
      chk_out("bp_hold", 2'd0, 7'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_resume_grant", 32'(req_ready), 32'b0010);
    tick();
    chk_out("bp_resume", 2'd1, 7'd2);
    req_valid = '0;
    tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Single requester 2, directed conversions
    vals[0] = 6'b111101; exps[0] = 7'b1000011;
    vals[1] = 6'b000101; exps[1] = 7'b0000101;
    vals[2] = 6'b100000; exps[2] = 7'b1100000;
    vals[3] = 6'b000000; exps[3] = 7'b0000000;
    req_valid = 4'b0100;
    for (int i = 0; i < 4; i++) begin
      set_data(2, vals[i]);
      #1;
      chk("single_grant", 32'(req_ready), 32'b0100);
      tick();
      chk_out("single", 2'd2, exps[i]);
    end

    // Exhaustive sweep through requester 3
    req_valid = 4'b1000;
    for (int v = 0; v < 64; v++) begin
      set_data(3, 6'(v));
      tick();
      chk("sweep", {23'd0, out_valid, out_id, out_data}, {23'd0, 1'b1, 2'd3, golden(v)});
    end
    req_valid = '0;
    tick();
    chk("sweep_drain", 32'(out_valid), 32'd0);

    // Fairness with random traffic on 1 and 3, req 0 always pending
    m_valid = 1'b0; m_id = '0; m_ptr = 0; pend = 4'b0001;
    for (int k = 0; k < NR; k++) begin
      wait_cnt[k] = 0; issued[k] = 0; consumed[k] = 0;
    end
    for (int c = 0; c < 80; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      pend[0] = 1'b1;
      if (!pend[1] && $urandom_range(0, 1) == 1) begin pend[1] = 1'b1; set_data(1, 6'($urandom)); end
      if (!pend[3] && $urandom_range(0, 1) == 1) begin pend[3] = 1'b1; set_data(3, 6'($urandom)); end
      req_valid = pend;
      #1;
      acc = !m_valid || out_ready;
      exp_gnt = '0; g = -1;
      if (acc) begin
        for (int i = 0; i < NR; i++) begin
          if (g < 0 && pend[(m_ptr + i) % NR]) g = (m_ptr + i) % NR;
        end
      end
      if (g >= 0) exp_gnt[g] = 1'b1;
      chk("fair_grant", 32'(req_ready), 32'(exp_gnt));
      chk("fair_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) chk("fair_id", 32'(out_id), 32'(m_id));
      if (m_valid && out_ready) consumed[m_id]++;
      if (acc) begin
        for (int k = 0; k < NR; k++) if (pend[k]) wait_cnt[k]++;
      end
      if (g >= 0) begin
        chk("fair_wait", 32'(wait_cnt[g] <= NR), 32'd1);
        wait_cnt[g] = 0;
        issued[g]++;
        m_valid = 1'b1; m_id = 2'(g); m_ptr = (g + 1) % NR;
        if (g != 0) pend[g] = 1'b0;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end
    req_valid = '0; out_ready = 1'b1;
    #1;
    if (m_valid) consumed[m_id]++;
    tick();
    chk("fair_drain", 32'(out_valid), 32'd0);
    for (int k = 0; k < NR; k++) begin
      chk("fair_count", 32'(consumed[k]), 32'(issued[k]));
      $display("id %0d issued=%0d consumed=%0d", k, issued[k], consumed[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
